// File: rtl/polygon_loader_if.sv
// Request, vertex-memory and committed-polygon signals of polygon_loader.
// The bbox members exist only when POLYGON_LOADER_BBOX_EN is defined.
interface polygon_loader_if #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 32,
    parameter int ADDR_BITS        = 10
);
    localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1);

    logic                         start_in;
    logic [ADDR_BITS-1:0]         base_addr_in;
    logic [CNT_W-1:0]             count_in;
    logic [ADDR_BITS-1:0]         mem_addr_out;
    logic signed [WORLD_BITS-1:0] mem_x_in;
    logic signed [WORLD_BITS-1:0] mem_y_in;
    logic                         busy_out;
    logic                         done_out;
    logic                         error_out;
    logic signed [WORLD_BITS-1:0] poly_xs_out [MAX_NUM_VERTICES];
    logic signed [WORLD_BITS-1:0] poly_ys_out [MAX_NUM_VERTICES];
    logic [CNT_W-1:0]             num_points_out;
`ifdef POLYGON_LOADER_BBOX_EN
    logic signed [WORLD_BITS-1:0] bbox_xmin_out;
    logic signed [WORLD_BITS-1:0] bbox_xmax_out;
    logic signed [WORLD_BITS-1:0] bbox_ymin_out;
    logic signed [WORLD_BITS-1:0] bbox_ymax_out;
`endif

    modport master (
        input  start_in, base_addr_in, count_in, mem_x_in, mem_y_in,
        output mem_addr_out, busy_out, done_out, error_out,
               poly_xs_out, poly_ys_out, num_points_out
`ifdef POLYGON_LOADER_BBOX_EN
        , output bbox_xmin_out, bbox_xmax_out, bbox_ymin_out, bbox_ymax_out
`endif
    );

    modport slave (
        output start_in, base_addr_in, count_in, mem_x_in, mem_y_in,
        input  mem_addr_out, busy_out, done_out, error_out,
               poly_xs_out, poly_ys_out, num_points_out
`ifdef POLYGON_LOADER_BBOX_EN
        , input bbox_xmin_out, bbox_xmax_out, bbox_ymin_out, bbox_ymax_out
`endif
    );
endinterface

// File: rtl/polygon_loader.sv
// Loads a polygon's vertices from memory into shadow arrays and commits them atomically.
// Define POLYGON_LOADER_BBOX_EN to add a committed bounding box alongside the arrays.
module polygon_loader #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 32,
    parameter int ADDR_BITS        = 10,
    parameter int MEM_LATENCY      = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    polygon_loader_if.master bus
);
    localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1);
    localparam int IDX_W = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;

    typedef logic signed [WORLD_BITS-1:0] coord_t;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] issue_idx;
    logic             vld_p [MEM_LATENCY];
    logic [IDX_W-1:0] tag_p [MEM_LATENCY];
    coord_t           shadow_x [MAX_NUM_VERTICES];
    coord_t           shadow_y [MAX_NUM_VERTICES];

    logic             emerge;
    logic             last_cap;
    logic [IDX_W-1:0] tag_out;
    logic [IDX_W-1:0] last_idx;

    assign emerge   = vld_p[MEM_LATENCY-1];
    assign tag_out  = tag_p[MEM_LATENCY-1];
    assign last_idx = IDX_W'(cnt - CNT_W'(1));
    assign last_cap = emerge && (tag_out == last_idx);

`ifdef POLYGON_LOADER_BBOX_EN
    coord_t run_xmin, run_xmax, run_ymin, run_ymax;
    coord_t nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;

    function automatic coord_t smin(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t smax(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

    // Running box including the vertex emerging this cycle; vertex 0 reseeds it.
    always_comb begin
        nxt_xmin = run_xmin;
        nxt_xmax = run_xmax;
        nxt_ymin = run_ymin;
        nxt_ymax = run_ymax;
        if (emerge) begin
            if (tag_out == '0) begin
                nxt_xmin = bus.mem_x_in;
                nxt_xmax = bus.mem_x_in;
                nxt_ymin = bus.mem_y_in;
                nxt_ymax = bus.mem_y_in;
            end else begin
                nxt_xmin = smin(run_xmin, bus.mem_x_in);
                nxt_xmax = smax(run_xmax, bus.mem_x_in);
                nxt_ymin = smin(run_ymin, bus.mem_y_in);
                nxt_ymax = smax(run_ymax, bus.mem_y_in);
            end
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state              <= IDLE;
            cnt                <= '0;
            issue_idx          <= '0;
            bus.busy_out       <= 1'b0;
            bus.done_out       <= 1'b0;
            bus.error_out      <= 1'b0;
            bus.mem_addr_out   <= '0;
            bus.num_points_out <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                tag_p[i] <= '0;
            end
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                shadow_x[i]        <= '0;
                shadow_y[i]        <= '0;
                bus.poly_xs_out[i] <= '0;
                bus.poly_ys_out[i] <= '0;
            end
`ifdef POLYGON_LOADER_BBOX_EN
            run_xmin <= '0; run_xmax <= '0; run_ymin <= '0; run_ymax <= '0;
            bus.bbox_xmin_out <= '0; bus.bbox_xmax_out <= '0;
            bus.bbox_ymin_out <= '0; bus.bbox_ymax_out <= '0;
`endif
        end else begin
            bus.done_out  <= 1'b0;
            bus.error_out <= 1'b0;

            // Tag pipeline: stage 0 records the index issued this cycle
            vld_p[0] <= (state == FETCH);
            tag_p[0] <= issue_idx;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                tag_p[i] <= tag_p[i-1];
            end

            if (emerge) begin
                shadow_x[tag_out] <= bus.mem_x_in;
                shadow_y[tag_out] <= bus.mem_y_in;
            end
`ifdef POLYGON_LOADER_BBOX_EN
            run_xmin <= nxt_xmin; run_xmax <= nxt_xmax;
            run_ymin <= nxt_ymin; run_ymax <= nxt_ymax;
`endif

            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        if (bus.count_in == '0 || bus.count_in > CNT_W'(MAX_NUM_VERTICES)) begin
                            bus.error_out <= 1'b1;
                        end else begin
                            state            <= FETCH;
                            bus.busy_out     <= 1'b1;
                            cnt              <= bus.count_in;
                            issue_idx        <= '0;
                            bus.mem_addr_out <= bus.base_addr_in;
                        end
                    end
                end
                FETCH: begin
                    if (issue_idx == last_idx) begin
                        state <= DRAIN;
                    end else begin
                        issue_idx        <= issue_idx + IDX_W'(1);
                        bus.mem_addr_out <= bus.mem_addr_out + ADDR_BITS'(1);
                    end
                end
                DRAIN: begin
                    // Commit on the final capture edge, forwarding that vertex so done and
                    // the new arrays become visible together in the COMMIT cycle.
                    if (last_cap) begin
                        state              <= COMMIT;
                        bus.done_out       <= 1'b1;
                        bus.num_points_out <= cnt;
                        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                            if (CNT_W'(i) >= cnt) begin
                                bus.poly_xs_out[i] <= '0;
                                bus.poly_ys_out[i] <= '0;
                            end else if (tag_out == IDX_W'(i)) begin
                                bus.poly_xs_out[i] <= bus.mem_x_in;
                                bus.poly_ys_out[i] <= bus.mem_y_in;
                            end else begin
                                bus.poly_xs_out[i] <= shadow_x[i];
                                bus.poly_ys_out[i] <= shadow_y[i];
                            end
                        end
`ifdef POLYGON_LOADER_BBOX_EN
                        bus.bbox_xmin_out <= nxt_xmin; bus.bbox_xmax_out <= nxt_xmax;
                        bus.bbox_ymin_out <= nxt_ymin; bus.bbox_ymax_out <= nxt_ymax;
`endif
                    end
                end
                COMMIT: begin
                    state        <= IDLE;
                    bus.busy_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
